// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// State encoding and frame bit constants used by uart_tx_drain and uart_baud_cnt.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // A one-bit counter still needs one flop when the bit period is tiny.
    function automatic int cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// 'clear' holds it at zero so a frame always starts on a clean bit boundary.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// FIFO-draining UART transmitter: pops bytes via rd/empty/data_out and sends 8N1 frames LSB first.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits (11-bit frames).
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    output logic       rd,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       tick;
    logic       clear;
`ifdef UART_PARITY_EN
    logic       parity_bit;
`endif

    // Baud counter is held at zero until the frame proper begins in START.
    assign clear = (state == IDLE) || (state == FETCH) || (state == WAIT);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!empty) next_state = FETCH;
            FETCH: next_state = WAIT;
            WAIT:  next_state = START;
            START: if (tick) next_state = DATA;
            DATA: begin
                if (tick && (bit_idx == LAST_BIT)) begin
`ifdef UART_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (tick) next_state = STOP;
`endif
            STOP:  if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // fifo_data is only valid in WAIT, one cycle after the rd strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_idx   <= '0;
`ifdef UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (state == WAIT) begin
            shift_reg <= fifo_data;
            bit_idx   <= '0;
`ifdef UART_PARITY_EN
            parity_bit <= ^fifo_data;
`endif
        end else if ((state == DATA) && tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx != LAST_BIT) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        rd   = 1'b0;
        tx   = STOP_BIT;
        busy = (state != IDLE);
        done = 1'b0;
        case (state)
            FETCH:  rd = 1'b1;
            START:  tx = START_BIT;
            DATA:   tx = shift_reg[0];
`ifdef UART_PARITY_EN
            PARITY: tx = parity_bit;
`endif
            STOP:   done = tick;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain with a FIFO model and a frame scoreboard.
// Honours UART_PARITY_EN to expect 11-bit frames with an even-parity bit.
module tb_uart_tx_drain;

    localparam int N = 4;
`ifdef UART_PARITY_EN
    localparam int L = 11;
`else
    localparam int L = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       rd;
    logic       tx;
    logic       busy;
    logic       done;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         gap_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         frames_ok = 0;
    int         done_count = 0;
    int         rd_count = 0;
    int         rd_in_frame = 0;
    int         rd_when_empty = 0;
    int         cyc = 0;
    int         rd_cyc = 0;
    int         pos = 0;
    int         gap_cnt = 0;
    bit         active = 1'b0;
    bit         bit_bad = 1'b0;
    bit         gap_track = 1'b0;
    logic [10:0] frame_bits = '1;
    exp_t       cur;

    always #5 clk = ~clk;

    uart_tx_drain #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .fifo_data(fifo_data),
        .rd       (rd),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic par);
        exp_t e;
        e.data   = b;
        e.parity = par;
        fifo_q.push_back(b);
        exp_q.push_back(e);
        empty = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while ((frames_ok < target) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_timeout", 32'(frames_ok >= target), 32'd1);
    endtask

    // FIFO model plus frame monitor; everything sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rd === 1'b1) begin
            rd_count++;
            rd_cyc = cyc;
            if (active) rd_in_frame++;
            if (fifo_q.size() == 0) begin
                rd_when_empty++;
            end else begin
                fifo_data = fifo_q.pop_front();
                empty = (fifo_q.size() == 0);
            end
        end
        if (done === 1'b1) done_count++;
        if (rst) begin
            active = 1'b0;
            gap_track = 1'b0;
            bit_bad = 1'b0;
        end else begin
            if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    pos = 0;
                    bit_bad = 1'b0;
                    if (gap_track) gap_q.push_back(gap_cnt);
                    gap_track = 1'b0;
                    checkOutput("rd_to_start", 32'(cyc - rd_cyc), 32'd2);
                    checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) cur = exp_q[0];
                    else cur.data = 8'h00;
                    frame_bits = '1;
                    frame_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) frame_bits[i+1] = cur.data[i];
`ifdef UART_PARITY_EN
                    frame_bits[9] = cur.parity;
`endif
                end else if (gap_track && (tx === 1'b1)) begin
                    gap_cnt++;
                end
            end
            if (active) begin
                if (tx !== frame_bits[pos/N]) bit_bad = 1'b1;
                if (done !== (pos == L*N-1)) bit_bad = 1'b1;
                if (busy !== 1'b1) bit_bad = 1'b1;
                if ((pos % N) == N-1) begin
                    checkOutput($sformatf("byte%02h_bit%0d", cur.data, pos/N), 32'(bit_bad), 32'd0);
                    bit_bad = 1'b0;
                end
                if (pos == L*N-1) begin
                    active = 1'b0;
                    frames_ok++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    gap_track = 1'b1;
                    gap_cnt = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    initial begin
        exp_t table_v[3];
        logic [7:0] b2b[3];
        int rd0;
        int n;

        table_v[0].data = 8'hA5; table_v[0].parity = 1'b0;
        table_v[1].data = 8'h07; table_v[1].parity = 1'b1;
        table_v[2].data = 8'h03; table_v[2].parity = 1'b0;
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;

        // Reset held with data waiting: nothing may move until release.
        rst = 1'b1;
        applyStimulus(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_tx", 32'(tx), 32'd1);
            checkOutput("rst_rd", 32'(rd), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rd_after_rst", 32'(rd), 32'd1);
        wait_frames(frames_ok + 1, 2*L*N + 20);

        for (int i = 0; i < 3; i++) begin
            rd0 = rd_count;
            applyStimulus(table_v[i].data, table_v[i].parity);
            wait_frames(frames_ok + 1, 2*L*N + 20);
            @(negedge clk);
            checkOutput($sformatf("idle_busy_%02h", table_v[i].data), 32'(busy), 32'd0);
            checkOutput($sformatf("rd_pulses_%02h", table_v[i].data), 32'(rd_count - rd0), 32'd1);
        end

        // Back-to-back frames must be separated by exactly three idle-high cycles.
        gap_q.delete();
        rd0 = rd_count;
        for (int i = 0; i < 3; i++) applyStimulus(b2b[i], ^b2b[i]);
        wait_frames(frames_ok + 3, 4*L*N + 40);
        repeat (4) @(negedge clk);
        checkOutput("b2b_rd_pulses", 32'(rd_count - rd0), 32'd3);
        checkOutput("b2b_gap_count", 32'(gap_q.size()), 32'd3);
        if (gap_q.size() == 3) begin
            checkOutput("b2b_gap1", 32'(gap_q[1]), 32'd3);
            checkOutput("b2b_gap2", 32'(gap_q[2]), 32'd3);
        end

        // Reset during data bit 3 discards the byte; the next one still goes out.
        applyStimulus(8'h96, 1'b0);
        applyStimulus(8'h11, 1'b0);
        n = 0;
        while (!(active && (pos >= 17)) && (n < 4*L*N)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_bit3", 32'(active && (pos >= 17)), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_tx", 32'(tx), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_rd", 32'(rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_front());
        wait_frames(frames_ok + 1, 2*L*N + 20);

        // Byte arriving during STOP is fetched at the following IDLE, not earlier.
        applyStimulus(8'h42, 1'b0);
        n = 0;
        while (!(active && (pos >= (L-1)*N)) && (n < 4*L*N)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_stop", 32'(active && (pos >= (L-1)*N)), 32'd1);
        rd0 = rd_count;
        applyStimulus(8'h81, 1'b0);
        wait_frames(frames_ok + 2, 4*L*N + 40);
        checkOutput("late_rd_pulses", 32'(rd_count - rd0), 32'd1);
        checkOutput("late_gap", 32'(gap_q.size() != 0 ? gap_q[$] : -1), 32'd3);

        repeat (5) @(negedge clk);
        checkOutput("rd_in_frame", 32'(rd_in_frame), 32'd0);
        checkOutput("rd_when_empty", 32'(rd_when_empty), 32'd0);
        checkOutput("done_count", 32'(done_count), 32'(frames_ok));
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
